// File: rtl/spi_tx_arbiter_if.sv
// rtl/spi_tx_arbiter_if.sv - requester/FIFO-write bundle for the SPI TX arbiter
interface spi_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   gnt;
    logic                 busy;
    logic                 tx_ready;
    logic [7:0]           tx_data;
    logic                 fifo_f;

    // Requester/FIFO side: drives requests and the full flag.
    modport master (
        output req, req_data, req_last, fifo_f,
        input  ack, gnt, busy, tx_ready, tx_data
    );

    // Arbiter side.
    modport slave (
        input  req, req_data, req_last, fifo_f,
        output ack, gnt, busy, tx_ready, tx_data
    );
endinterface

// File: rtl/spi_tx_arbiter.sv
// rtl/spi_tx_arbiter.sv - round-robin write-side arbiter for the SPI async FIFO
module spi_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              sys_clk,
    input  logic              rst,
    spi_tx_arbiter_if.slave   bus
);
    localparam int              IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]      LAST_BEAT = 8'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] gnt_idx_nxt;
    logic [IDX_W-1:0] last_gnt;
    logic [IDX_W-1:0] last_gnt_nxt;
    logic [7:0]       beat_cnt;
    logic [7:0]       beat_cnt_nxt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             accept;
    logic [7:0]       req_bytes [NUM_REQ];

    // Unpack the flat data bus so the output mux indexes by requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = bus.req_data[8*g +: 8];
    end

    // Round-robin pick: first active request after the last owner.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_gnt) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_vld && bus.req[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    // Next-state and outputs; bytes only move in GRANT and never during rst.
    always_comb begin
        state_nxt    = state;
        gnt_idx_nxt  = gnt_idx;
        last_gnt_nxt = last_gnt;
        beat_cnt_nxt = beat_cnt;
        accept       = 1'b0;
        bus.tx_ready = 1'b0;
        bus.ack      = '0;
        bus.gnt      = '0;
        bus.busy     = 1'b0;
        bus.tx_data  = 8'h00;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_idx_nxt  = pick_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                bus.busy          = 1'b1;
                bus.gnt[gnt_idx]  = 1'b1;
                bus.tx_data       = req_bytes[gnt_idx];
                accept            = bus.req[gnt_idx] & ~bus.fifo_f & ~rst;
                bus.tx_ready      = accept;
                bus.ack[gnt_idx]  = accept;
                if (!bus.req[gnt_idx]) begin
                    // Withdrawal releases the grant even while the FIFO is full.
                    state_nxt    = IDLE;
                    last_gnt_nxt = gnt_idx;
                end else if (accept) begin
                    if (beat_cnt != LAST_BEAT) begin
                        beat_cnt_nxt = beat_cnt + 8'd1;
                    end
                    if (bus.req_last[gnt_idx] || beat_cnt == LAST_BEAT) begin
                        state_nxt    = IDLE;
                        last_gnt_nxt = gnt_idx;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset leaves requester 0 with first priority.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            last_gnt <= LAST_IDX;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt_idx  <= gnt_idx_nxt;
            last_gnt <= last_gnt_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb/tb_spi_tx_arbiter.sv - self-checking bench for spi_tx_arbiter
module tb_spi_tx_arbiter;
    localparam int N  = 4;
    localparam int MB = 8;

    logic sys_clk = 1'b0;
    logic rst;
    always #5 sys_clk = ~sys_clk;

    spi_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    spi_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: owner of the bus (-1 = none), last owner, bytes sent in burst.
    int owner = -1;
    int ptr   = N - 1;
    int sent  = 0;
    int acc_who;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle();
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_ack;
        logic         e_tx;
        logic [7:0]   e_data;
        bit           found;
        @(negedge sys_clk);
        e_gnt = '0; e_ack = '0; e_tx = 1'b0; e_data = 8'h00; acc_who = -1;
        if (owner >= 0) begin
            e_gnt[owner] = 1'b1;
            if (bus.req[owner] && !bus.fifo_f && !rst) begin
                e_tx = 1'b1;
                e_ack[owner] = 1'b1;
                e_data = bus.req_data[8*owner +: 8];
                acc_who = owner;
            end
        end
        check("gnt", 32'(bus.gnt), 32'(e_gnt));
        check("ack", 32'(bus.ack), 32'(e_ack));
        check("tx_ready", 32'(bus.tx_ready), 32'(e_tx));
        check("busy", 32'(bus.busy), (owner >= 0) ? 32'd1 : 32'd0);
        if (e_tx) check("tx_data", 32'(bus.tx_data), 32'(e_data));
        @(posedge sys_clk);
        if (rst) begin
            owner = -1; ptr = N - 1; sent = 0;
        end else if (owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && bus.req[(ptr + k) % N]) begin
                    found = 1'b1;
                    owner = (ptr + k) % N;
                    sent  = 0;
                end
            end
        end else if (!bus.req[owner]) begin
            ptr = owner; owner = -1;
        end else if (acc_who >= 0) begin
            sent++;
            if (bus.req_last[owner] || sent == MB) begin
                ptr = owner; owner = -1;
            end
        end
        #1;
    endtask

    task automatic run_acks(input int who, input int n, input int bound, output int got);
        got = 0;
        for (int c = 0; c < bound && got < n; c++) begin
            bus.req_data = $urandom;
            cycle();
            if (acc_who == who) got++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = '0; bus.req_last = '0; bus.fifo_f = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    int got;

    initial begin
        rst = 1'b1; bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.fifo_f = 1'b0;
        cycle();
        cycle();
        check("rst_tx_data", 32'(bus.tx_data), 32'h0);
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        rst = 1'b0;

        // Single one-byte packet from requester 0.
        bus.req = 4'b0001; bus.req_data = 32'h0000_00A5; bus.req_last = 4'b0001;
        cycle();
        check("t1_gnt", 32'(bus.gnt), 32'h1);
        check("t1_data", 32'(bus.tx_data), 32'hA5);
        cycle();
        bus.req = '0;
        cycle();
        cycle();

        // All requesting, one-byte packets: rotation.
        do_reset();
        bus.req = 4'b1111; bus.req_last = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            bus.req_data = $urandom;
            cycle();
        end
        bus.req = '0;
        cycle();

        // Long stream from requester 2 is split at MAX_BURST.
        bus.req = 4'b0100; bus.req_last = '0;
        run_acks(2, 10, 40, got);
        check("t3_bytes", 32'(got), 32'd10);
        bus.req = '0;
        cycle();

        // FIFO full for 3 cycles after byte 3.
        bus.req = 4'b0001; bus.req_last = '0;
        run_acks(0, 3, 20, got);
        bus.fifo_f = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        bus.fifo_f = 1'b0;
        run_acks(0, 1, 3, got);
        check("t4_resume", 32'(got), 32'd1);
        bus.req = '0;
        cycle();

        // Requester 1 withdraws mid-burst while 3 waits.
        do_reset();
        bus.req = 4'b1010; bus.req_last = '0;
        run_acks(1, 2, 20, got);
        bus.req = 4'b1000;
        cycle();
        cycle();
        check("t5_gnt", 32'(bus.gnt), 32'h8);
        bus.req = '0;
        cycle();
        cycle();

        // Reset during byte 5 restores requester 0 priority.
        do_reset();
        bus.req = 4'b1000; bus.req_last = '0;
        run_acks(3, 4, 20, got);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.req = 4'b1001;
        cycle();
        check("t6_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        cycle();
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int r = 0; r < N; r++) begin
                bus.req[r]      = ($urandom_range(0, 9) < 7);
                bus.req_last[r] = ($urandom_range(0, 3) == 0);
            end
            bus.req_data = $urandom;
            bus.fifo_f   = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
